// File: rtl/mips_ifu_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mips_ifu_if : fetch-unit bundle (imem port + decode/control handshake) |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface mips_ifu_if;
    logic [1:0]  pc_src;
    logic        zero;
    logic [31:0] rs_data;
    logic        instr_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        misalign;
    logic [31:0] instret;

    modport master (
        input  pc_src, zero, rs_data, instr_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, instr, instr_valid, pc, pc_plus8,
               misalign, instret
    );

    modport slave (
        output pc_src, zero, rs_data, instr_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus8,
               misalign, instret
    );
endinterface
`default_nettype wire

// File: rtl/mips_ifu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mips_ifu : instruction fetch unit, PC register and next-PC selection  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mips_ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  wire logic   clk,
    input  wire logic   reset,
    mips_ifu_if.master  bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instret_q, instret_d;
    logic        misalign_q, misalign_d;

    logic        handshake;
    logic [31:0] p4;
    logic [31:0] br_off;
    logic [31:0] npc;

    always_comb begin
        p4     = pc_q + 32'd4;
        br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        unique case (bus.pc_src)
            2'd0:    npc = p4;
            2'd1:    npc = bus.zero ? (p4 + br_off) : p4;
            2'd2:    npc = {p4[31:28], instr_q[25:0], 2'b00};
            default: npc = {bus.rs_data[31:2], 2'b00};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instret_d  = instret_q;
        misalign_d = 1'b0;
        handshake  = 1'b0;
        unique case (state_q)
            FETCH: state_d = WAIT;
            WAIT: begin
                if (bus.imem_rvalid) begin
                    instr_d = bus.imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (bus.instr_ready) begin
                    handshake  = 1'b1;
                    pc_d       = npc;
                    instret_d  = instret_q + 32'd1;
                    misalign_d = (bus.pc_src == 2'd3) && (bus.rs_data[1:0] != 2'b00);
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            instret_q  <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instret_q  <= instret_d;
            misalign_q <= misalign_d;
        end
    end

    // The request is gated by reset so nothing is issued while reset is held.
    assign bus.imem_req    = (state_q == FETCH) && !reset;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state_q == VALID);
    assign bus.pc          = pc_q;
    assign bus.pc_plus8    = pc_q + 32'd8;
    assign bus.misalign    = misalign_q;
    assign bus.instret     = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_ifu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mips_ifu : scoreboard bench for the instruction fetch unit         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_mips_ifu;

    typedef struct {
        logic [31:0] word;
        logic [1:0]  src;
        logic        zero;
        logic [31:0] rs;
        logic [31:0] next;
        logic        mis;
    } step_t;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    int   exp_instret;

    logic [31:0] q_addr[$];
    logic [31:0] exp_instr[$];

    mips_ifu_if bus ();

    mips_ifu #(.RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for a request, answers it one cycle later; ends at a VALID negedge.
    task automatic serve(input logic [31:0] word, output logic [31:0] addr,
                         output int waited, output bit ok);
        waited = 0;
        while (!bus.imem_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        ok   = bus.imem_req;
        addr = bus.imem_addr;
        if (!ok) return;
        @(negedge clk);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word;
        exp_instr.push_back(word);
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
    endtask

    task automatic accept(input logic [1:0] src, input logic z, input logic [31:0] rs);
        bus.instr_ready = 1'b1;
        bus.pc_src      = src;
        bus.zero        = z;
        bus.rs_data     = rs;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.pc_src      = 2'($urandom);
        bus.zero        = 1'($urandom);
        bus.rs_data     = $urandom;
        exp_instret++;
    endtask

    task automatic test_reset();
        logic [31:0] a, ea;
        int          wt;
        bit          ok;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.misalign !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: req=%b valid=%b mis=%b, required 0/0/0",
                     bus.imem_req, bus.instr_valid, bus.misalign);
        end
        tests_run++;
        if (bus.pc !== 32'h3000 || bus.instret !== 32'd0 || bus.instr !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_regs: pc=%h instret=%h instr=%h, required 3000/0/0",
                     bus.pc, bus.instret, bus.instr);
        end
        reset = 1'b0;
        #1;
        q_addr.push_back(32'h3000);
        serve(32'h1111_1111, a, wt, ok);
        ea = q_addr.pop_front();
        tests_run++;
        if (!ok || wt != 0 || a !== ea) begin
            tests_failed++;
            $display("FAIL first_req: ok=%0d wait=%0d addr=%h, required 1/0/%h", ok, wt, a, ea);
        end
        tests_run++;
        if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h3000 || bus.pc_plus8 !== 32'h3008) begin
            tests_failed++;
            $display("FAIL first_valid: valid=%b pc=%h pc8=%h, required 1/3000/3008",
                     bus.instr_valid, bus.pc, bus.pc_plus8);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] words[3];
        logic [31:0] a, ea, ei, cur;
        int          wt;
        bit          ok;
        words[0] = 32'h1111_1111;
        words[1] = 32'h2222_2222;
        words[2] = 32'h3333_3333;
        cur = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                serve(words[i], a, wt, ok);
                ea = q_addr.pop_front();
                cur = ea;
                tests_run++;
                if (!ok || a !== ea) begin
                    tests_failed++;
                    $display("FAIL seq_addr[%0d]: ok=%0d addr=%h, required %h", i, ok, a, ea);
                end
            end
            ei = exp_instr.pop_front();
            tests_run++;
            if (bus.instr !== ei || bus.pc !== cur || bus.pc_plus8 !== cur + 32'd8) begin
                tests_failed++;
                $display("FAIL seq_instr[%0d]: instr=%h pc=%h pc8=%h, required %h/%h/%h",
                         i, bus.instr, bus.pc, bus.pc_plus8, ei, cur, cur + 32'd8);
            end
            accept(2'd0, 1'b0, 32'h0);
            q_addr.push_back(cur + 32'd4);
        end
        tests_run++;
        if (bus.instret !== 32'd3) begin
            tests_failed++;
            $display("FAIL seq_instret: got %0d, required 3", bus.instret);
        end
    endtask

    task automatic test_branch();
        step_t       st[4];
        logic [31:0] a, ea, ei;
        int          wt;
        bit          ok;
        st[0] = '{32'h0000_0000, 2'd0, 1'b0, 32'h0, 32'h3010, 1'b0};
        st[1] = '{32'h1000_FFFE, 2'd1, 1'b1, 32'h0, 32'h300C, 1'b0};
        st[2] = '{32'h0000_0000, 2'd0, 1'b1, 32'h0, 32'h3010, 1'b0};
        st[3] = '{32'h1000_FFFE, 2'd1, 1'b0, 32'h0, 32'h3014, 1'b0};
        for (int i = 0; i < 4; i++) begin
            serve(st[i].word, a, wt, ok);
            ea = q_addr.pop_front();
            ei = exp_instr.pop_front();
            tests_run++;
            if (!ok || a !== ea || bus.instr !== ei || bus.pc !== ea) begin
                tests_failed++;
                $display("FAIL branch[%0d]: ok=%0d addr=%h instr=%h pc=%h, required addr/pc %h instr %h",
                         i, ok, a, bus.instr, bus.pc, ea, ei);
            end
            accept(st[i].src, st[i].zero, st[i].rs);
            q_addr.push_back(st[i].next);
        end
    endtask

    task automatic test_jump();
        step_t       st[4];
        logic [31:0] a, ea, ei;
        int          wt;
        bit          ok;
        st[0] = '{32'h0000_0000, 2'd3, 1'b0, 32'h0000_3000, 32'h3000, 1'b0};
        st[1] = '{32'h0800_0C40, 2'd2, 1'b1, 32'hFFFF_FFFF, 32'h3100, 1'b0};
        st[2] = '{32'h0000_0000, 2'd3, 1'b0, 32'h0000_3000, 32'h3000, 1'b0};
        st[3] = '{32'hABCD_0000, 2'd3, 1'b1, 32'h0000_3207, 32'h3204, 1'b1};
        for (int i = 0; i < 4; i++) begin
            serve(st[i].word, a, wt, ok);
            ea = q_addr.pop_front();
            ei = exp_instr.pop_front();
            tests_run++;
            if (!ok || a !== ea || bus.instr !== ei) begin
                tests_failed++;
                $display("FAIL jump[%0d]: ok=%0d addr=%h instr=%h, required %h/%h",
                         i, ok, a, bus.instr, ea, ei);
            end
            accept(st[i].src, st[i].zero, st[i].rs);
            q_addr.push_back(st[i].next);
            tests_run++;
            if (bus.misalign !== st[i].mis) begin
                tests_failed++;
                $display("FAIL misalign[%0d]: got %b, required %b", i, bus.misalign, st[i].mis);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, ea, ei;
        int          wt;
        bit          ok;
        serve(32'hDEAD_BEEF, a, wt, ok);
        ea = q_addr.pop_front();
        tests_run++;
        if (!ok || a !== ea || bus.misalign !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_addr: ok=%0d addr=%h mis=%b, required 1/%h/0", ok, a, bus.misalign, ea);
        end
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = 32'hBAD0_BAD0;
            end
            @(negedge clk);
            bus.imem_rvalid = 1'b0;
            tests_run++;
            if (bus.instr !== exp_instr[0] || bus.pc !== ea || bus.imem_req !== 1'b0 ||
                bus.instr_valid !== 1'b1 || bus.instret !== 32'(exp_instret)) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: instr=%h pc=%h req=%b valid=%b instret=%0d, required %h/%h/0/1/%0d",
                         c, bus.instr, bus.pc, bus.imem_req, bus.instr_valid, bus.instret,
                         exp_instr[0], ea, exp_instret);
            end
        end
        ei = exp_instr.pop_front();
        accept(2'd0, 1'b0, 32'h0);
        q_addr.push_back(ea + 32'd4);
        tests_run++;
        if (bus.instret !== 32'(exp_instret)) begin
            tests_failed++;
            $display("FAIL bp_instret: got %0d, required %0d", bus.instret, exp_instret);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] a, ea, ei;
        int          wt;
        bit          ok;
        ea = q_addr.pop_front();
        tests_run++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== ea) begin
            tests_failed++;
            $display("FAIL rw_req: req=%b addr=%h, required 1/%h", bus.imem_req, bus.imem_addr, ea);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== 32'h3000 ||
            bus.instret !== 32'd0) begin
            tests_failed++;
            $display("FAIL rw_reset: req=%b valid=%b pc=%h instret=%0d, required 0/0/3000/0",
                     bus.imem_req, bus.instr_valid, bus.pc, bus.instret);
        end
        reset = 1'b0;
        exp_instret = 0;
        #1;
        q_addr.push_back(32'h3000);
        serve(32'h4444_4444, a, wt, ok);
        ea = q_addr.pop_front();
        ei = exp_instr.pop_front();
        tests_run++;
        if (!ok || wt != 0 || a !== ea) begin
            tests_failed++;
            $display("FAIL rw_restart: ok=%0d wait=%0d addr=%h, required 1/0/%h", ok, wt, a, ea);
        end
        tests_run++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== ei || bus.instret !== 32'd0) begin
            tests_failed++;
            $display("FAIL rw_instr: valid=%b instr=%h instret=%0d, required 1/%h/0",
                     bus.instr_valid, bus.instr, bus.instret, ei);
        end
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        exp_instret     = 0;
        reset           = 1'b1;
        bus.pc_src      = 2'd0;
        bus.zero        = 1'b0;
        bus.rs_data     = 32'd0;
        bus.instr_ready = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_backpressure();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mips_ifu.md
Name: mips_ifu

Overview:
- Instruction fetch unit. Sits directly upstream of the main control decoder and consumes its PC-select code (pc_src) plus the ALU zero flag and the rs register value.
- Owns the PC register and the next-PC computation.
- Issues one instruction-memory request at a time and presents the fetched word, with a valid/ready handshake, to decode/control.
- Also supplies pc_plus8 for jal link write-back and a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset; must be word-aligned.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
pc_src  input  2  0:pc+4, 1:beq, 2:j/jal, 3:jr; sampled only at handshake
zero  input  1  ALU zero for beq; sampled only at handshake
rs_data  input  32  jr target; sampled only at handshake
instr_ready  input  1  downstream accepts current instruction
imem_req  output  1  one-cycle fetch request strobe
imem_addr  output  32  fetch address (= pc)
imem_rvalid  input  1  response valid, one cycle
imem_rdata  input  32  instruction word
instr  output  32  held instruction register
instr_valid  output  1  instr/pc valid for decode
pc  output  32  address of instr
pc_plus8  output  32  pc + 8 (jal link value)
misalign  output  1  one-cycle pulse: jr target low bits non-zero
instret  output  32  accepted-instruction count

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, misalign=0, instret=0, state=FETCH.
  - The instruction memory shares the same reset and discards any in-flight request.
- FSM states: FETCH, WAIT, VALID.
- FETCH:
  - imem_req=1 and imem_addr=pc for exactly this cycle.
  - Next state: WAIT.
  - An imem_rvalid arriving in FETCH is ignored.
- WAIT:
  - imem_req=0; wait indefinitely.
  - On imem_rvalid: instr<=imem_rdata, next state VALID.
- VALID:
  - instr_valid=1; instr and pc held stable while instr_ready=0.
  - On instr_ready=1 (handshake):
    - pc<=npc
    - instret<=instret+1 (wraps 0xFFFF_FFFF->0)
    - instr_valid deasserts next cycle
    - next state FETCH.
  - imem_rvalid in VALID or FETCH is a protocol error; it is ignored.
- Latency and throughput:
  - The first imem_req occurs in the first cycle after reset deasserts.
  - The minimum is 3 cycles per instruction (FETCH, WAIT with same-earliest rvalid, VALID+ready).
- npc (32-bit, all additions modulo 2^32):
  - p4 = pc + 4.
  - pc_src=0: p4.
  - pc_src=1: zero ? p4 + (sext(instr[15:0]) << 2) : p4.
  - pc_src=2: {p4[31:28], instr[25:0], 2'b00}.
  - pc_src=3: {rs_data[31:2], 2'b00}. If rs_data[1:0]!=0, misalign=1 for the cycle after the handshake; otherwise 0.
- pc_plus8 = pc + 8, combinational from the pc register; wraps.
- pc_src, zero and rs_data are don't-care outside the handshake cycle.
- Reset asserted in any state (e.g. mid-WAIT) restarts at FETCH with pc=RESET_PC. No stale instruction may reach instr_valid.

Test Plan:
- Reset held 2 cycles then released, imem returns rvalid 1 cycle after req -> imem_req at cycle 1 with imem_addr=0x3000; instr_valid at cycle 3; pc=0x3000, pc_plus8=0x3008.
- Three handshakes with pc_src=0, rdata 0x11111111/0x22222222/0x33333333 -> imem_addr 0x3000, 0x3004, 0x3008; instret=3.
- Branches at pc=0x3010:
  - instr=0x1000FFFE, pc_src=1, zero=1 -> next imem_addr=0x300C.
  - Same with zero=0 -> 0x3014.
- Jumps at pc=0x3000:
  - instr=0x08000C40, pc_src=2 -> next imem_addr=0x0000_3100.
  - pc_src=3, rs_data=0x00003207 -> next addr 0x3204, misalign pulses 1 cycle.
- Backpressure: instr_ready low 5 cycles in VALID -> instr/pc stable, no imem_req, instret unchanged; the stray imem_rvalid injected in VALID is ignored.
- Reset asserted during WAIT, then memory returns nothing for the old request -> restart at 0x3000; instr_valid=0 until the new response; instret=0.
